mcpu_boot_ctrl: RTL and testbench
=================================

# mcpu_boot_ctrl

Boot-and-run controller for the MCPU. It holds the CPU in reset and streams a program image into instruction RAM from address 0 over a valid/ready port. It zero-fills the remainder of RAM, then releases the CPU and monitors the program counter until it reaches a programmed halt address or a cycle budget expires. It replaces back-door RAM/register initialisation with a synthesizable load path and gives benches and the top level a single done/timeout status.

## Interface
- WORD_SIZE, 16, RAM word / instruction width
- ADDR_SIZE, 8, RAM address width; RAM depth = 2^ADDR_SIZE
- CYC_WIDTH, 32, width of run-cycle counter
- MAX_CYCLES, 100000, run-cycle budget before timeout (must be < 2^CYC_WIDTH)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin load/run; sampled only in IDLE, DONE
- halt_addr  in  ADDR_SIZE  PC value meaning "program finished"; latched on accepted start
- ld_valid  in  1  load word valid
- ld_ready  out  1  controller accepts load word
- ld_data  in  WORD_SIZE  program word
- ld_last  in  1  marks final program word
- mem_we  out  1  RAM write strobe (registered)
- mem_addr  out  ADDR_SIZE  RAM write address (registered)
- mem_wdata  out  WORD_SIZE  RAM write data (registered)
- cpu_reset  out  1  active-high reset to MCPU
- cpu_pc  in  ADDR_SIZE  MCPU program counter
- busy  out  1  high in LOAD, FILL, RUN
- done  out  1  run ended (halt or timeout), sticky until next start
- timeout  out  1  run ended by budget, sticky until next start
- cycles  out  CYC_WIDTH  RUN cycles elapsed

## Operation
- States: IDLE, LOAD, FILL, RUN, DONE.
- IDLE: cpu_reset=1, ld_ready=0, mem_we=0. On start=1, go to LOAD. The same edge also latches halt_addr, sets the address counter to 0, and clears done, timeout and cycles.
- LOAD: ld_ready=1. Each ld_valid&ld_ready edge registers mem_we=1, mem_addr=counter and mem_wdata=ld_data for the next cycle, then increments the counter.
  - Accepted word with ld_last=1 at address < 2^ADDR_SIZE-1: go to FILL.
  - Accepted word at address 2^ADDR_SIZE-1, with or without ld_last: implicit last, go straight to RUN with no FILL.
  - ld_valid gaps are allowed. No write is issued on idle cycles.
- FILL: ld_ready=0. One zero-word write per cycle to the addresses from (last address+1) through 2^ADDR_SIZE-1, then go to RUN. The counter must not wrap to 0.
- RUN: cpu_reset=0, mem_we=0. cycles increments once per RUN cycle.
  - Halt: cpu_pc==latched halt_addr while cycles!=0 sets done=1 and moves to DONE. This excludes the first RUN cycle, so halt_addr=0 does not fire on the reset PC.
  - Timeout: cycles reaching MAX_CYCLES sets done=1, timeout=1 and moves to DONE. Halt and timeout on the same cycle report halt (timeout=0).
- DONE: cpu_reset stays 0 so register state remains observable. cycles is frozen. start=1 behaves as in IDLE, reloads, and reasserts cpu_reset=1 from the next cycle.
- start is ignored in LOAD, FILL and RUN. ld_valid outside LOAD is ignored.
- All arithmetic is unsigned. The address counter is ADDR_SIZE+1 bits internally to detect the end of RAM.

## Timing
- Reset values (asynchronous, immediate on reset=0): state IDLE, cpu_reset=1, ld_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, timeout=0, cycles=0.
- Reset mid-operation aborts any state with no further RAM writes. RAM contents are left as-is.
- start at edge T: ld_ready=1 and busy=1 from cycle T+1.
- A word accepted at edge A is written on edge A+1 (mem_we high during cycle A+1).
- Last word accepted at address k at edge L: the FILL write to k+1 is visible in cycle L+2, one address per cycle, with the final fill write at address 2^ADDR_SIZE-1. cpu_reset falls the cycle after that final write's strobe cycle.
- The halt/timeout decision at edge H makes done=1 visible in cycle H+1. cycles holds the count of RUN cycles including cycle H.
- Throughput: 1 load word per cycle when ld_valid is held high.

## Test plan
- Reset: assert reset=0 mid-RUN with arbitrary inputs -> all outputs at reset values in the same cycle; cpu_reset=1; no mem_we while reset=0.
- Short load: start, 3 words 0xA108/0xA215/0x1021 with one ld_valid gap, ld_last on the third -> writes at addresses 0,1,2 with that data, then 253 zero writes at 3..255, then cpu_reset=0.
- Full load: 256 words, ld_last never asserted -> last write at 255, no FILL writes, RUN entered, ld_ready=0 after the 256th acceptance.
- Halt: 20-word Collatz program, halt_addr=19 -> done=1 and timeout=0 one cycle after cpu_pc==19; cycles frozen; start pulses during RUN have no effect.
- Timeout: MAX_CYCLES=100, program with an unconditional self-branch, halt_addr=0xFF -> done=1, timeout=1, cycles=100.
- Restart: from DONE, start with new halt_addr -> done/timeout/cycles cleared next cycle, cpu_reset=1, LOAD entered, new image overwrites from address 0.

Source files
------------

// File: rtl/mcpu_boot_ctrl.sv
// Boot-and-run controller: streams a program image into instruction RAM, zero-fills the rest,
// then releases the MCPU and watches its PC for a halt address or a cycle-budget timeout.
module mcpu_boot_ctrl #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned ADDR_SIZE  = 8,
    parameter int unsigned CYC_WIDTH  = 32,
    parameter int unsigned MAX_CYCLES = 100000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [ADDR_SIZE-1:0] halt_addr_i,
    input  logic                 ld_valid_i,
    output logic                 ld_ready_o,
    input  logic [WORD_SIZE-1:0] ld_data_i,
    input  logic                 ld_last_i,
    output logic                 mem_we_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [WORD_SIZE-1:0] mem_wdata_o,
    output logic                 cpu_reset_o,
    input  logic [ADDR_SIZE-1:0] cpu_pc_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [CYC_WIDTH-1:0] cycles_o
);

    typedef enum logic [2:0] {StIdle, StLoad, StFill, StRun, StDone} state_e;

    localparam logic [ADDR_SIZE:0]   LastAddr = {1'b0, {ADDR_SIZE{1'b1}}};
    localparam logic [CYC_WIDTH-1:0] MaxCyc   = CYC_WIDTH'(MAX_CYCLES);

    state_e               state_q, state_d;
    // One extra bit so the fill pass can see "past the end" without wrapping to 0.
    logic [ADDR_SIZE:0]   addr_q, addr_d;
    logic [ADDR_SIZE-1:0] halt_q, halt_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic [CYC_WIDTH-1:0] cycles_q, cycles_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        halt_d      = halt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        cycles_d    = cycles_q;
        ld_ready_o  = 1'b0;
        cpu_reset_o = 1'b1;
        busy_o      = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                // DONE keeps the CPU out of reset so its state stays observable.
                cpu_reset_o = (state_q == StIdle);
                if (start_i) begin
                    state_d   = StLoad;
                    halt_d    = halt_addr_i;
                    addr_d    = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    cycles_d  = '0;
                end
            end
            StLoad: begin
                ld_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (ld_valid_i) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q[ADDR_SIZE-1:0];
                    mem_wdata_d = ld_data_i;
                    addr_d      = addr_q + 1'b1;
                    if (addr_q == LastAddr) begin
                        state_d = StRun;
                    end else if (ld_last_i) begin
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                busy_o = 1'b1;
                if (addr_q[ADDR_SIZE]) begin
                    state_d = StRun;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q[ADDR_SIZE-1:0];
                    mem_wdata_d = '0;
                    addr_d      = addr_q + 1'b1;
                end
            end
            StRun: begin
                cpu_reset_o = 1'b0;
                busy_o      = 1'b1;
                cycles_d    = cycles_q + 1'b1;
                // cycles_q != 0 skips the first RUN cycle, where the PC still holds its reset value.
                if (cpu_pc_i == halt_q && cycles_q != '0) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (cycles_d == MaxCyc) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            halt_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            halt_q      <= halt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            cycles_q    <= cycles_d;
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_mcpu_boot_ctrl.sv
// Directed bench for mcpu_boot_ctrl: vector table for the load handshake, hand-written
// sequences for fill, halt, timeout, restart and asynchronous reset.
module tb_mcpu_boot_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [7:0]  halt_addr_i;
    logic        ld_valid_i;
    logic        ld_ready_o;
    logic [15:0] ld_data_i;
    logic        ld_last_i;
    logic        mem_we_o;
    logic [7:0]  mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic        cpu_reset_o;
    logic [7:0]  cpu_pc_i;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;
    logic [31:0] cycles_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    mcpu_boot_ctrl #(
        .WORD_SIZE (16),
        .ADDR_SIZE (8),
        .CYC_WIDTH (32),
        .MAX_CYCLES(100)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .halt_addr_i(halt_addr_i),
        .ld_valid_i (ld_valid_i),
        .ld_ready_o (ld_ready_o),
        .ld_data_i  (ld_data_i),
        .ld_last_i  (ld_last_i),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .cpu_reset_o(cpu_reset_o),
        .cpu_pc_i   (cpu_pc_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .timeout_o  (timeout_o),
        .cycles_o   (cycles_o)
    );

    typedef struct {
        logic        start;
        logic [7:0]  halt;
        logic        vld;
        logic [15:0] data;
        logic        last;
        logic        e_rdy;
        logic        e_we;
        logic [7:0]  e_addr;
        logic [15:0] e_wdata;
        logic        e_cpurst;
        logic        e_busy;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_run(input int budget);
        int n;
        n = 0;
        while (cpu_reset_o !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        chk("run_entry_in_budget", 64'(cpu_reset_o), 64'd0);
    endtask

    task automatic load_one(input logic [7:0] halt, input logic [15:0] word);
        start_i     = 1'b1;
        halt_addr_i = halt;
        step();
        start_i    = 1'b0;
        ld_valid_i = 1'b1;
        ld_data_i  = word;
        ld_last_i  = 1'b1;
        step();
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
    endtask

    initial begin
        int n;
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        halt_addr_i = '0;
        ld_valid_i  = 1'b0;
        ld_data_i   = '0;
        ld_last_i   = 1'b0;
        cpu_pc_i    = '0;

        // start, word, gap, word, last word, then the first two fill writes
        vecs[0] = '{1'b1, 8'd19, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd0, 16'h0000, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 8'd0,  1'b1, 16'hA108, 1'b0, 1'b1, 1'b1, 8'd0, 16'hA108, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 8'd0,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd0, 16'hA108, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 8'd0,  1'b1, 16'hA215, 1'b0, 1'b1, 1'b1, 8'd1, 16'hA215, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 8'd0,  1'b1, 16'h1021, 1'b1, 1'b0, 1'b1, 8'd2, 16'h1021, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'd0,  1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd3, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 8'd0,  1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd4, 16'h0000, 1'b1, 1'b1};

        #2;
        chk("rst_cpu_reset", 64'(cpu_reset_o), 64'd1);
        chk("rst_ld_ready", 64'(ld_ready_o), 64'd0);
        chk("rst_mem_we", 64'(mem_we_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_cycles", 64'(cycles_o), 64'd0);
        step();
        rst_ni = 1'b1;
        step();
        chk("idle_busy", 64'(busy_o), 64'd0);

        // Short load via the vector table
        for (int i = 0; i < 7; i++) begin
            start_i     = vecs[i].start;
            halt_addr_i = vecs[i].halt;
            ld_valid_i  = vecs[i].vld;
            ld_data_i   = vecs[i].data;
            ld_last_i   = vecs[i].last;
            step();
            chk($sformatf("vec%0d_ld_ready", i), 64'(ld_ready_o), 64'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_mem_we", i), 64'(mem_we_o), 64'(vecs[i].e_we));
            chk($sformatf("vec%0d_mem_addr", i), 64'(mem_addr_o), 64'(vecs[i].e_addr));
            chk($sformatf("vec%0d_mem_wdata", i), 64'(mem_wdata_o), 64'(vecs[i].e_wdata));
            chk($sformatf("vec%0d_cpu_reset", i), 64'(cpu_reset_o), 64'(vecs[i].e_cpurst));
            chk($sformatf("vec%0d_busy", i), 64'(busy_o), 64'(vecs[i].e_busy));
        end
        for (int a = 5; a < 256; a++) begin
            step();
            chk("fill_write", {mem_we_o, mem_addr_o, mem_wdata_o, cpu_reset_o},
                {1'b1, 8'(a), 16'h0000, 1'b1});
        end
        step();
        chk("fill_end_we", 64'(mem_we_o), 64'd0);
        chk("fill_end_cpu_reset", 64'(cpu_reset_o), 64'd0);
        chk("run_busy", 64'(busy_o), 64'd1);

        // Halt at PC 19; start and ld_valid pulses mid-run must be ignored
        for (int k = 1; k <= 20; k++) begin
            cpu_pc_i   = 8'(k - 1);
            start_i    = (k == 5);
            ld_valid_i = (k == 7);
            step();
            start_i    = 1'b0;
            ld_valid_i = 1'b0;
            if (k < 20) begin
                chk("run_not_done", {done_o, cpu_reset_o, mem_we_o, ld_ready_o}, 4'b0000);
            end
        end
        chk("halt_done", 64'(done_o), 64'd1);
        chk("halt_timeout", 64'(timeout_o), 64'd0);
        chk("halt_cycles", 64'(cycles_o), 64'd20);
        chk("halt_busy", 64'(busy_o), 64'd0);
        chk("halt_cpu_reset", 64'(cpu_reset_o), 64'd0);
        cpu_pc_i = 8'd7;
        step();
        step();
        step();
        chk("done_cycles_frozen", 64'(cycles_o), 64'd20);
        chk("done_sticky", 64'(done_o), 64'd1);

        // Restart from DONE, full 256-word image without ld_last
        start_i     = 1'b1;
        halt_addr_i = 8'hFF;
        step();
        start_i = 1'b0;
        chk("restart_done", 64'(done_o), 64'd0);
        chk("restart_cycles", 64'(cycles_o), 64'd0);
        chk("restart_cpu_reset", 64'(cpu_reset_o), 64'd1);
        chk("restart_ld_ready", 64'(ld_ready_o), 64'd1);
        for (int i = 0; i < 256; i++) begin
            ld_valid_i = 1'b1;
            ld_data_i  = 16'h5000 + 16'(i);
            step();
            chk("full_write", {mem_we_o, mem_addr_o, mem_wdata_o}, {1'b1, 8'(i), 16'h5000 + 16'(i)});
            if (i == 255) begin
                chk("full_ld_ready_low", 64'(ld_ready_o), 64'd0);
                chk("full_run_cpu_reset", 64'(cpu_reset_o), 64'd0);
            end
        end
        ld_valid_i = 1'b0;
        cpu_pc_i   = 8'd5;
        n = 0;
        while (done_o !== 1'b1 && n < 300) begin
            step();
            n++;
            if (n == 1) chk("full_no_fill_we", 64'(mem_we_o), 64'd0);
        end
        chk("timeout_done", 64'(done_o), 64'd1);
        chk("timeout_flag", 64'(timeout_o), 64'd1);
        chk("timeout_cycles", 64'(cycles_o), 64'd100);

        // halt_addr = 0 must not fire on the first RUN cycle
        load_one(8'h00, 16'hBEEF);
        chk("start_clears_timeout", 64'(timeout_o), 64'd0);
        wait_run(400);
        cpu_pc_i = 8'd0;
        step();
        chk("halt0_first_cycle", {done_o, 32'(cycles_o)}, {1'b0, 32'd1});
        step();
        chk("halt0_second_cycle", {done_o, timeout_o, 32'(cycles_o)}, {1'b1, 1'b0, 32'd2});

        // Asynchronous reset mid-RUN
        load_one(8'hFF, 16'h1234);
        wait_run(400);
        cpu_pc_i = 8'd3;
        step();
        step();
        #3;
        rst_ni      = 1'b0;
        start_i     = 1'b1;
        ld_valid_i  = 1'b1;
        #1;
        chk("async_rst_outputs",
            {cpu_reset_o, ld_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, timeout_o},
            {1'b1, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0});
        chk("async_rst_cycles", 64'(cycles_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_held_no_write", {mem_we_o, cpu_reset_o}, 2'b01);
        end
        start_i    = 1'b0;
        ld_valid_i = 1'b0;
        rst_ni     = 1'b1;
        step();
        chk("post_rst_idle", {busy_o, ld_ready_o}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
